// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and the cipher rounds.
// Holds the S-box table, GF(2^8) doubling, the key-expander FSM state
// type and the set of legal key lengths.
package aes_pkg;

    localparam int KEY_BITS_128 = 128;
    localparam int KEY_BITS_192 = 192;
    localparam int KEY_BITS_256 = 256;

    typedef enum logic [1:0] {
        IDLE,
        EMIT_KEY,
        EXPAND
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo the AES polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit is_legal_key_bits(input int bits);
        return (bits == KEY_BITS_128) || (bits == KEY_BITS_192) || (bits == KEY_BITS_256);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// Ports: data  - input byte
//        subst - substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] subst
);

    assign subst = SBOX[data];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule: accepts a 128/192/256-bit key and streams
// the expanded schedule one 32-bit word per clock.
// Ports: clk, rst (synchronous, active high)
//        start, key_in  - request / key, sampled in IDLE only
//        busy           - schedule in progress
//        wk_valid, wk_idx, wk - streamed schedule word w[wk_idx]
//        done           - one-cycle pulse after the last word
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                wk_valid,
    output logic [5:0]          wk_idx,
    output logic [31:0]         wk,
    output logic                done
);

    localparam int NK = KEY_BITS / 32;
    localparam int NW = 4 * (NK + 7);

    if (!is_legal_key_bits(KEY_BITS)) begin : g_bad_key_bits
        $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
    end

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        emit_key;
    logic        emit_exp;
    logic        finish;

    // win[0] is w[i-NK], win[NK-1] is w[i-1] while expanding.
    logic [31:0] win [NK];
    logic [7:0]  rcon;
    logic [2:0]  imod;

    logic [31:0] t_word;
    logic [31:0] sbox_in;
    logic [31:0] sub_word;
    logic [31:0] temp;
    logic [31:0] new_word;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control. The output registers are loaded on
    // the edge that leaves each state, so the state names describe what the
    // next edge will produce, not what is currently on wk.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        emit_key   = 1'b0;
        emit_exp   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = EMIT_KEY;
                end
            end
            EMIT_KEY: begin
                emit_key = 1'b1;
                if (wk_idx == 6'(NK - 2)) begin
                    next_state = EXPAND;
                end
            end
            EXPAND: begin
                if (wk_idx == 6'(NW - 1)) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end else begin
                    emit_exp = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Next schedule word. The S-box sees RotWord(t) on the rcon step and
    // plain t otherwise, so four S-boxes cover both SubWord uses.
    assign t_word  = win[NK-1];
    assign sbox_in = (imod == 3'd0) ? {t_word[23:0], t_word[31:24]} : t_word;

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (
            .data  (sbox_in[8*b +: 8]),
            .subst (sub_word[8*b +: 8])
        );
    end

    always_comb begin
        temp = t_word;
        if (imod == 3'd0) begin
            temp = sub_word ^ {rcon, 24'h0};
        end else if ((NK == 8) && (imod == 3'd4)) begin
            temp = sub_word;
        end
    end

    assign new_word = win[0] ^ temp;

    // Key window. It is captured rotated by one word because w[0] goes
    // straight to wk on the accept edge; after the remaining NK-1 key words
    // have been emitted the window is back in w[0]..w[NK-1] order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                for (int j = 0; j < NK - 1; j++) begin
                    win[j] <= key_in[KEY_BITS-1-32*(j+1) -: 32];
                end
                win[NK-1] <= key_in[KEY_BITS-1 -: 32];
            end else if (emit_key || emit_exp) begin
                for (int j = 0; j < NK - 1; j++) begin
                    win[j] <= win[j+1];
                end
                win[NK-1] <= emit_key ? win[0] : new_word;
            end
        end
    end

    // Output registers, word index, i mod NK counter and round constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            wk_valid <= 1'b0;
            done     <= 1'b0;
            wk       <= 32'h0;
            wk_idx   <= 6'd0;
            rcon     <= 8'h01;
            imod     <= 3'd0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy     <= 1'b1;
                wk_valid <= 1'b1;
                wk       <= key_in[KEY_BITS-1 -: 32];
                wk_idx   <= 6'd0;
                rcon     <= 8'h01;
                imod     <= 3'd0;
            end
            if (emit_key) begin
                wk     <= win[0];
                wk_idx <= wk_idx + 6'd1;
            end
            if (emit_exp) begin
                wk     <= new_word;
                wk_idx <= wk_idx + 6'd1;
                imod   <= (imod == 3'(NK - 1)) ? 3'd0 : imod + 3'd1;
                if (imod == 3'd0) begin
                    rcon <= xtime(rcon);
                end
            end
            if (finish) begin
                busy     <= 1'b0;
                wk_valid <= 1'b0;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: one instance per key size,
// a FIPS-197 reference schedule built from first principles (GF(2^8)
// inverse + affine S-box), directed anchors and random keys.
module tb_aes_key_expander;

    logic         clk;
    logic         rst;
    logic         start;
    int           sel;
    logic [255:0] key_reg;

    logic         start_a, start_b, start_c;
    logic         busy_a, busy_b, busy_c;
    logic         valid_a, valid_b, valid_c;
    logic [5:0]   idx_a, idx_b, idx_c;
    logic [31:0]  wk_a, wk_b, wk_c;
    logic         done_a, done_b, done_c;

    logic         sel_busy, sel_valid, sel_done;
    logic [5:0]   sel_idx;
    logic [31:0]  sel_wk;

    int           checks;
    int           errors;
    logic [7:0]   sbox_ref [256];
    logic [31:0]  exp_w [60];
    logic [31:0]  obs_w [60];

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    aes_key_expander #(.KEY_BITS(128)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .key_in(key_reg[255:128]),
        .busy(busy_a), .wk_valid(valid_a), .wk_idx(idx_a), .wk(wk_a), .done(done_a)
    );
    aes_key_expander #(.KEY_BITS(192)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key_in(key_reg[255:64]),
        .busy(busy_b), .wk_valid(valid_b), .wk_idx(idx_b), .wk(wk_b), .done(done_b)
    );
    aes_key_expander #(.KEY_BITS(256)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .key_in(key_reg),
        .busy(busy_c), .wk_valid(valid_c), .wk_idx(idx_c), .wk(wk_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the instance under test to one set of observation signals.
    always_comb begin
        sel_busy  = busy_a;
        sel_valid = valid_a;
        sel_done  = done_a;
        sel_idx   = idx_a;
        sel_wk    = wk_a;
        if (sel == 1) begin
            sel_busy = busy_b; sel_valid = valid_b; sel_done = done_b;
            sel_idx  = idx_b;  sel_wk    = wk_b;
        end else if (sel == 2) begin
            sel_busy = busy_c; sel_valid = valid_c; sel_done = done_c;
            sel_idx  = idx_c;  sel_wk    = wk_c;
        end
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    function automatic logic [31:0] subword_ref(input logic [31:0] w);
        return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Reference schedule from the FIPS-197 recurrence, key taken left-aligned.
    task automatic compute_schedule(input int nk);
        int nw = 4 * (nk + 7);
        for (int i = 0; i < nw; i++) begin
            if (i < nk) begin
                exp_w[i] = key_reg[255 - 32*i -: 32];
            end else begin
                logic [31:0] t = exp_w[i-1];
                if (i % nk == 0) begin
                    logic [7:0] rc = 8'h01;
                    for (int m = 1; m < i / nk; m++) rc = gf_mul(rc, 8'h02);
                    t = subword_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                end else if (nk == 8 && i % nk == 4) begin
                    t = subword_ref(t);
                end
                exp_w[i] = exp_w[i-nk] ^ t;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Select an instance, load a key, build its reference and raise start
    // for the upcoming rising edge.
    task automatic applyStimulus(input int s, input logic [255:0] key);
        sel     = s;
        key_reg = key;
        compute_schedule(4 + 2 * s);
        start   = 1'b1;
    endtask

    function automatic logic [255:0] random_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Follow one stream from wk_idx=0 to the done cycle; optionally poke
    // start with another key mid-stream, which must be ignored.
    task automatic stream_check(input int nw, input bit poke, input string name);
        for (int k = 0; k < nw; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (poke && k == 5) begin
                start   = 1'b1;
                key_reg = random_key();
            end
            if (poke && k == 6) start = 1'b0;
            obs_w[k] = sel_wk;
            checkOutput($sformatf("%s ctl[%0d]", name, k), {29'b0, sel_valid, sel_busy, sel_done}, 32'h6);
            checkOutput($sformatf("%s idx[%0d]", name, k), 32'(sel_idx), 32'(k));
            checkOutput($sformatf("%s w[%0d]", name, k), sel_wk, exp_w[k]);
        end
        @(negedge clk);
        checkOutput($sformatf("%s done ctl", name), {29'b0, sel_valid, sel_busy, sel_done}, 32'h1);
        checkOutput($sformatf("%s hold idx", name), 32'(sel_idx), 32'(nw - 1));
        checkOutput($sformatf("%s hold wk", name), sel_wk, exp_w[nw-1]);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] k128;
        logic [255:0] k192;
        logic [255:0] k256;
        checks  = 0;
        errors  = 0;
        sel     = 0;
        start   = 1'b0;
        key_reg = '0;
        rst     = 1'b1;
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        build_sbox();
        checkOutput("sbox ref 00", 32'(sbox_ref[0]), 32'h63);

        // Reset state of all three instances.
        repeat (2) @(negedge clk);
        checkOutput("reset ctl a", {29'b0, valid_a, busy_a, done_a}, 32'h0);
        checkOutput("reset ctl b", {29'b0, valid_b, busy_b, done_b}, 32'h0);
        checkOutput("reset ctl c", {29'b0, valid_c, busy_c, done_c}, 32'h0);
        checkOutput("reset wk", wk_a | wk_b | wk_c, 32'h0);
        checkOutput("reset idx", 32'(idx_a | idx_b | idx_c), 32'h0);
        rst = 1'b0;

        // Idle: no start for 100 cycles.
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checkOutput($sformatf("idle[%0d]", c),
                        {29'b0, valid_a | valid_b | valid_c, busy_a | busy_b | busy_c, done_a | done_b | done_c}, 32'h0);
        end

        // FIPS-197 AES-128 vector, then back-to-back start in the done cycle.
        applyStimulus(0, k128);
        stream_check(44, 1'b0, "aes128");
        checkOutput("aes128 w4", obs_w[4], 32'ha0fafe17);
        checkOutput("aes128 w43", obs_w[43], 32'hb6630ca6);
        applyStimulus(0, random_key());
        stream_check(44, 1'b0, "b2b128");

        // FIPS-197 AES-192 vector.
        @(negedge clk);
        applyStimulus(1, k192);
        stream_check(52, 1'b0, "aes192");
        checkOutput("aes192 w6", obs_w[6], 32'hfe0c91f7);
        checkOutput("aes192 w51", obs_w[51], 32'h01002202);

        // FIPS-197 AES-256 vector.
        @(negedge clk);
        applyStimulus(2, k256);
        stream_check(60, 1'b0, "aes256");
        checkOutput("aes256 w8", obs_w[8], 32'h9ba35411);
        checkOutput("aes256 w12", obs_w[12], 32'ha8b09c1a);
        checkOutput("aes256 w59", obs_w[59], 32'h706c631e);

        // start while busy must be ignored.
        @(negedge clk);
        applyStimulus(0, random_key());
        stream_check(44, 1'b1, "busy128");
        @(negedge clk);
        checkOutput("busy128 no requeue", {29'b0, sel_valid, sel_busy, sel_done}, 32'h0);

        // Reset mid-run at wk_idx=20, with start held during reset.
        applyStimulus(0, k128);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            checkOutput($sformatf("pre-rst w[%0d]", k), sel_wk, exp_w[k]);
        end
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checkOutput("rst ctl", {29'b0, sel_valid, sel_busy, sel_done}, 32'h0);
        checkOutput("rst wk", sel_wk, 32'h0);
        checkOutput("rst idx", 32'(sel_idx), 32'h0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("post-rst idle", {29'b0, sel_valid, sel_busy, sel_done}, 32'h0);
        applyStimulus(0, k128);
        stream_check(44, 1'b0, "rerun128");

        // Random keys on every size.
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                applyStimulus(s, random_key());
                stream_check(4 * (4 + 2 * s + 7), 1'b0, $sformatf("rand%0d_%0d", s, r));
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative, parametrised AES key-schedule engine. It accepts a 128/192/256-bit cipher key and streams the full expanded schedule, one 32-bit word per clock, to the round-key store of the AES core in the CAN-SEC datapath. The round constant is produced internally by a GF(2^8) doubling register, which replaces the fixed ten-entry constant lookup, so a single block serves all three key sizes.

## Interface
- KEY_BITS, 128: key length, legal values 128/192/256; any other value is an elaboration error.
- Derived constants: NK = KEY_BITS/32 (4/6/8); NR = NK+6 (10/12/14); NW = 4*(NR+1) (44/52/60).
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request expansion of key_in; sampled only in IDLE.
- key_in  in  KEY_BITS  cipher key; key_in[KEY_BITS-1 -: 32] is w[0] (FIPS-197 byte order). Captured on the accepted start cycle only.
- busy  out  1  high from the cycle after start is accepted until the last word is emitted.
- wk_valid  out  1  wk/wk_idx carry a valid schedule word.
- wk_idx  out  6  word index i, 0..NW-1.
- wk  out  32  schedule word w[i].
- done  out  1  single-cycle pulse after w[NW-1].

## Operation
- FSM states: IDLE, EMIT_KEY, EXPAND.
- IDLE: when start=1, capture key_in into an NK-word window, set rcon=8'h01, set idx=0, and go to EMIT_KEY. start is ignored in every other state, with no queuing.
- EMIT_KEY: emit window words w[0]..w[NK-1] at one per cycle. After idx=NK-1, go to EXPAND.
- EXPAND: compute and emit w[i] = w[i-NK] ^ temp, where t = w[i-1]:
  - i mod NK == 0: temp = SubWord(RotWord(t)) ^ {rcon,24'h0}. After this use, rcon <= xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1b : 8'h00).
  - NK==8 and i mod NK == 4: temp = SubWord(t).
  - otherwise: temp = t.
  - The window shifts by one word per cycle. Track i mod NK with a separate counter and do not use a divider.
- After emitting w[NW-1], go to IDLE and pulse done.
- RotWord is a left byte rotation: {a0,a1,a2,a3} -> {a1,a2,a3,a0}. SubWord applies the AES S-box to each byte independently.
- Maximum rcon values reached: 8'h36 for 128-bit keys, 8'h80 for 192-bit keys, 8'h40 for 256-bit keys. No wrap handling is needed.
- Reset, at any time including mid-expansion:
  - Returns the FSM to IDLE.
  - Forces busy=0, wk_valid=0, done=0, wk=0, wk_idx=0 and rcon=8'h01.
  - The partial schedule is discarded and not resumed.
- start asserted together with rst has no effect.

## Timing
- Accepted start in cycle T: busy=1 and wk_valid=1 with wk_idx=0 in cycle T+1.
- wk_idx=k appears in cycle T+1+k, gap-free. wk_valid stays high for exactly NW consecutive cycles.
- Cycle T+NW+1: done=1, busy=0, wk_valid=0. A new start is accepted in this same cycle, so back-to-back throughput is NW+1 cycles per key.
- All outputs are registered. wk and wk_idx hold their last value while wk_valid=0, except after reset, when they are 0.
- No downstream back-pressure: the consumer must accept a word every cycle.
- Critical path: one S-box, then the rcon XOR, then the w[i-NK] XOR, all inside one cycle.

## Structure
- Shared package aes_pkg holds:
  - the S-box constant array;
  - the xtime function;
  - the FSM state enum;
  - the legal KEY_BITS values.
- Sub-module aes_sbox: combinational 8-bit to 8-bit lookup, instantiated four times for SubWord. It is reusable by the cipher round.
- There is no separate round-constant module; the rcon register lives in this block.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - w[4]=a0fafe17 at T+5;
  - w[43]=b6630ca6 at T+44;
  - done at T+45;
  - 44 contiguous valid cycles.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: w[6]=fe0c91f7, w[51]=01002202, done at T+53.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - w[8]=9ba35411;
  - w[12]=a8b09c1a (SubWord-only path);
  - w[59]=706c631e;
  - done at T+61.
- start re-asserted with a different key while busy:
  - it is ignored, and the stream still matches the first key;
  - start asserted in the done cycle is accepted, and wk_idx=0 appears on the next cycle.
- rst asserted at wk_idx=20 of an AES-128 run:
  - the next cycle shows all outputs 0 and the FSM in IDLE;
  - a fresh start then reproduces the full correct 44-word schedule, confirming rcon was restored to 01.
- Idle bench: start=0 for 100 cycles gives wk_valid=0, busy=0 and done=0 throughout.
